// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - UART receive deframer: oversampled start detect, deserialise, error flags, RTS
//
// Ports:
//   Clk         sample clock, OVERSAMPLE x baud rate
//   Rst         asynchronous active-low reset
//   Rx          serial line, asynchronous to Clk
//   Rx_Hold     receive FIFO asks the sender to pause
//   Data_Out    last received data word (held between deliveries)
//   Data_Valid  one-cycle pulse when Data_Out/Rx_Error are updated
//   Rx_Error    [2] frame, [1] parity, [0] break
//   Rx_Busy     a frame is being received
//   RTS         high = sender may transmit
module uart_rx_deframer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_BIT = 1,
    parameter int STOP_BITS  = 2,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx,
    input  logic                 Rx_Hold,
    output logic [DATA_BITS-1:0] Data_Out,
    output logic                 Data_Valid,
    output logic [2:0]           Rx_Error,
    output logic                 Rx_Busy,
    output logic                 RTS
);
    localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BIT + STOP_BITS;
    localparam int H          = OVERSAMPLE / 2;
    localparam int CW         = $clog2(OVERSAMPLE);
    localparam int KW         = $clog2(FRAME_BITS + 1);

    localparam logic [CW-1:0] HALF_LAST   = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST    = CW'(OVERSAMPLE - 1);
    localparam logic [KW-1:0] K_LAST      = KW'(FRAME_BITS - 1);
    localparam logic [KW-1:0] K_DATA_LAST = KW'(DATA_BITS);
    localparam logic [KW-1:0] K_PARITY    = KW'(DATA_BITS + 1);
    localparam logic [KW-1:0] K_LAST_NSTP = KW'(DATA_BITS + PARITY_BIT);

    typedef enum logic [1:0] {IDLE, START, SHIFT, BREAK_WAIT} state_t;

    state_t               state;
    state_t               next_state;
    logic                 sync1;
    logic                 rxs;
    logic [CW-1:0]        cnt;
    logic [KW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS:0]   shift_next;
    logic                 par_bit;
    logic                 stop_err;
    logic                 any_one;

    logic                 sample_tick;
    logic                 frame_done;
    logic                 is_data;
    logic                 is_par;
    logic                 is_stop;

    logic                 dv_d;
    logic [DATA_BITS-1:0] data_d;
    logic [2:0]           err_d;
    logic                 busy_d;

    // START samples mid start bit; SHIFT samples mid every later bit.
    assign sample_tick = ((state == START) && (cnt == HALF_LAST)) ||
                         ((state == SHIFT) && (cnt == BIT_LAST));
    assign frame_done  = (state == SHIFT) && sample_tick && (bit_idx == K_LAST);
    assign is_data     = (bit_idx <= K_DATA_LAST);
    assign is_par      = (PARITY_BIT != 0) && (bit_idx == K_PARITY);
    assign is_stop     = (bit_idx > K_LAST_NSTP);
    assign shift_next  = {shreg, rxs};

    // Two-flop synchroniser, preset to the idle line level.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= Rx;
            rxs   <= sync1;
        end
    end

    // State register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (!rxs) next_state = START;
            START:      if (sample_tick) next_state = rxs ? IDLE : SHIFT;
            SHIFT:      if (frame_done) next_state = (any_one | rxs) ? IDLE : BREAK_WAIT;
            BREAK_WAIT: if (rxs) next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    // Output logic: values registered into the outputs at the next edge.
    // The final sample is always a stop bit, so it is folded in directly.
    always_comb begin
        dv_d   = frame_done;
        data_d = Data_Out;
        err_d  = Rx_Error;
        busy_d = (next_state == START) || (next_state == SHIFT);
        if (frame_done) begin
            if (!(any_one | rxs)) begin
                data_d = '0;
                err_d  = 3'b001;
            end else begin
                data_d = shreg;
                err_d  = {stop_err | !rxs,
                          (PARITY_BIT != 0) && (par_bit != ^shreg),
                          1'b0};
            end
        end
    end

    // Bit timing and frame accumulation
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_err <= 1'b0;
            any_one  <= 1'b0;
        end else begin
            if (((state == START) || (state == SHIFT)) && !sample_tick) begin
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
            end

            if ((state == IDLE) && !rxs) begin
                bit_idx  <= '0;
                stop_err <= 1'b0;
                any_one  <= 1'b0;
            end else if ((state == START) && sample_tick) begin
                bit_idx <= KW'(1);
            end else if ((state == SHIFT) && sample_tick) begin
                bit_idx <= bit_idx + KW'(1);
                any_one <= any_one | rxs;
                if (is_data) begin
                    shreg <= shift_next[DATA_BITS-1:0];
                end
                if (is_par) begin
                    par_bit <= rxs;
                end
                if (is_stop && !rxs) begin
                    stop_err <= 1'b1;
                end
            end
        end
    end

    // Registered outputs
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Data_Out   <= '0;
            Data_Valid <= 1'b0;
            Rx_Error   <= 3'b000;
            Rx_Busy    <= 1'b0;
            RTS        <= 1'b0;
        end else begin
            Data_Out   <= data_d;
            Data_Valid <= dv_d;
            Rx_Error   <= err_d;
            Rx_Busy    <= busy_d;
            RTS        <= !Rx_Hold;
        end
    end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - randomized bench with frame-level reference model for uart_rx_deframer
module tb_uart_rx_deframer;
    localparam int OS   = 16;
    localparam int H    = 8;
    localparam int FB   = 12;
    localparam int MAXC = 60000;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Rx = 1'b1;
    logic       Rx_Hold = 1'b0;
    logic [7:0] Data_Out;
    logic       Data_Valid;
    logic [2:0] Rx_Error;
    logic       Rx_Busy;
    logic       RTS;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: per-cycle expectations derived from each frame's bits.
    bit         exp_busy [MAXC];
    bit         exp_dv   [MAXC];
    logic [7:0] exp_data [MAXC];
    logic [2:0] exp_err  [MAXC];
    logic [7:0] held_data = 8'h00;
    logic [2:0] held_err  = 3'b000;
    logic       exp_rts   = 1'b0;
    bit         hold_rand = 1'b0;

    logic [7:0] cap_data = 8'h00;
    logic [2:0] cap_err  = 3'b000;
    int         cap_cyc  = 0;
    int         cap_n    = 0;

    uart_rx_deframer dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Rx         (Rx),
        .Rx_Hold    (Rx_Hold),
        .Data_Out   (Data_Out),
        .Data_Valid (Data_Valid),
        .Rx_Error   (Rx_Error),
        .Rx_Busy    (Rx_Busy),
        .RTS        (RTS)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;
    always @(posedge Clk) exp_rts <= Rst ? ~Rx_Hold : 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, expv);
        end
    endtask

    // Busy from S+1 through the last stop sample, delivery one cycle later.
    task automatic expect_frame(input int s, input bit [11:0] b, input logic [7:0] d);
        int last;
        last = s + H + (FB - 1) * OS;
        for (int n = s + 1; n <= last; n++) exp_busy[n] = 1'b1;
        exp_dv[last + 1] = 1'b1;
        if (b == 12'd0) begin
            exp_data[last + 1] = 8'h00;
            exp_err[last + 1]  = 3'b001;
        end else begin
            exp_data[last + 1] = d;
            exp_err[last + 1]  = {~(b[10] & b[11]), b[9] ^ (^d), 1'b0};
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        Rx  = 1'b1;
        for (int n = cyc; n < MAXC; n++) begin
            exp_busy[n] = 1'b0;
            exp_dv[n]   = 1'b0;
        end
        held_data = 8'h00;
        held_err  = 3'b000;
        #1;
        chk("rst_async_data", Data_Out, 8'h00);
        chk("rst_async_dv", Data_Valid, 1'b0);
        chk("rst_async_err", Rx_Error, 3'b000);
        chk("rst_async_busy", Rx_Busy, 1'b0);
        chk("rst_async_rts", RTS, 1'b0);
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b1;
        repeat (4) tick();
    endtask

    // Called at posedge+1; tail of idle line is OS-H-1+gap cycles after the last stop sample.
    task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit st1, input bit st2,
                              input int gap, input int abort_bit, output int s);
        bit [11:0] b;
        int        len;
        int        tail;
        b[0] = 1'b0;
        for (int k = 1; k <= 8; k++) b[k] = d[8 - k];
        b[9]  = par_ok ? (^d) : ~(^d);
        b[10] = st1;
        b[11] = st2;
        s = cyc + 2;
        expect_frame(s, b, d);
        for (int k = 0; k < FB; k++) begin
            len = (k == FB - 1) ? H + 1 : OS;
            for (int i = 0; i < len; i++) begin
                if (k == abort_bit && i == 3) begin
                    do_reset();
                    return;
                end
                Rx = b[k];
                tick();
            end
        end
        Rx = 1'b1;
        tail = OS - H - 1 + gap;
        if (b == 12'd0 && tail < 1) tail = 1;
        repeat (tail) tick();
    endtask

    task automatic send_break(input int extra, output int s);
        s = cyc + 2;
        expect_frame(s, 12'd0, 8'h00);
        Rx = 1'b0;
        repeat (FB * OS + extra) tick();
        Rx = 1'b1;
        repeat (4) tick();
    endtask

    task automatic glitch(input int w, output int s);
        s = cyc + 2;
        for (int n = s + 1; n <= s + H; n++) exp_busy[n] = 1'b1;
        Rx = 1'b0;
        repeat (w) tick();
        Rx = 1'b1;
        repeat (H + 2) tick();
    endtask

    // Compare process: every cycle, outputs against the model.
    initial begin
        forever begin
            @(negedge Clk);
            if (!Rst) begin
                chk("rst_data", Data_Out, 8'h00);
                chk("rst_dv", Data_Valid, 1'b0);
                chk("rst_err", Rx_Error, 3'b000);
                chk("rst_busy", Rx_Busy, 1'b0);
                chk("rst_rts", RTS, 1'b0);
            end else if (cyc < MAXC) begin
                if (exp_dv[cyc]) begin
                    held_data = exp_data[cyc];
                    held_err  = exp_err[cyc];
                end
                chk("dv", Data_Valid, exp_dv[cyc]);
                chk("busy", Rx_Busy, exp_busy[cyc]);
                chk("data", Data_Out, held_data);
                chk("err", Rx_Error, held_err);
                chk("rts", RTS, exp_rts);
            end
            if (Data_Valid) begin
                cap_data = Data_Out;
                cap_err  = Rx_Error;
                cap_cyc  = cyc;
                cap_n++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (hold_rand && $urandom_range(0, 9) == 0) Rx_Hold = ~Rx_Hold;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        int s;
        int n0;
        int r;
        int gap;
        logic [7:0] d;

        Rst = 1'b0;
        Rx = 1'b1;
        Rx_Hold = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_data", Data_Out, 8'h00);
        chk("reset_err", Rx_Error, 3'b000);
        chk("reset_busy", Rx_Busy, 1'b0);
        chk("reset_rts", RTS, 1'b0);
        Rst = 1'b1;
        tick();
        chk("rts_first", RTS, 1'b1);
        repeat (4) tick();

        // Valid 0xA5 with Rx_Hold raised mid-frame
        n0 = cap_n;
        fork
            send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 0, -1, s);
            begin
                repeat (90) @(posedge Clk);
                #1;
                Rx_Hold = 1'b1;
                tick();
                chk("rts_hold_low", RTS, 1'b0);
            end
        join
        chk("a5_data", cap_data, 8'hA5);
        chk("a5_err", cap_err, 3'b000);
        chk("a5_latency", cap_cyc - s, 185);
        chk("a5_count", cap_n - n0, 1);
        Rx_Hold = 1'b0;

        send_frame(8'hAA, 1'b0, 1'b1, 1'b1, 0, -1, s);
        chk("parity_data", cap_data, 8'hAA);
        chk("parity_err", cap_err, 3'b010);

        send_frame(8'hAA, 1'b1, 1'b0, 1'b0, 5, -1, s);
        chk("frame_data", cap_data, 8'hAA);
        chk("frame_err", cap_err, 3'b100);

        n0 = cap_n;
        send_break(40, s);
        chk("break_data", cap_data, 8'h00);
        chk("break_err", cap_err, 3'b001);
        chk("break_latency", cap_cyc - s, 185);
        chk("break_count", cap_n - n0, 1);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 0, -1, s);
        chk("after_break_data", cap_data, 8'h3C);
        chk("after_break_err", cap_err, 3'b000);

        n0 = cap_n;
        glitch(4, s);
        chk("glitch_count", cap_n - n0, 0);
        chk("glitch_busy", Rx_Busy, 1'b0);

        n0 = cap_n;
        send_frame(8'h77, 1'b1, 1'b1, 1'b1, 0, 5, s);
        chk("abort_count", cap_n - n0, 0);
        chk("abort_data", Data_Out, 8'h00);
        chk("abort_err", Rx_Error, 3'b000);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 0, -1, s);
        chk("after_reset_data", cap_data, 8'h5A);
        chk("after_reset_err", cap_err, 3'b000);

        // Randomized traffic, including back-to-back frames
        hold_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 11);
            if (r == 0) begin
                send_break($urandom_range(0, 60), s);
            end else if (r == 1) begin
                glitch($urandom_range(1, H), s);
            end else if (r == 2) begin
                send_frame(8'h00, 1'b1, 1'b0, 1'b0, $urandom_range(0, 10) - 7, -1, s);
            end else begin
                d   = 8'($urandom);
                gap = $urandom_range(0, 19) - 7;
                send_frame(d, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                           $urandom_range(0, 4) != 0, gap, -1, s);
            end
        end
        hold_rand = 1'b0;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive side of the UART serial link: oversamples the asynchronous Rx line, detects the start bit and deserialises one frame.
- Frame format: start(0), DATA_BITS MSB-first, optional even-parity bit, STOP_BITS stop bits (1).
- Delivers each frame's data with error flags {frame, parity, break} as a one-cycle Data_Valid pulse toward the receive FIFO.
- Drives RTS flow control from the FIFO's hold request.

Parameters:
- DATA_BITS, 8, data bits per frame (1..8).
- PARITY_BIT, 1, 1 = even-parity bit present, 0 = absent.
- STOP_BITS, 2, stop bits per frame (1..2).
- OVERSAMPLE, 16, Clk cycles per bit (even, 4..64).
- Local FRAME_BITS = 1 + DATA_BITS + PARITY_BIT + STOP_BITS.
- Local H = OVERSAMPLE/2.

Ports:
- Clk  in  1  sample clock, OVERSAMPLE x baud rate.
- Rst  in  1  reset, asynchronous, active-low.
- Rx  in  1  serial input, asynchronous to Clk.
- Rx_Hold  in  1  receive FIFO requests sender pause.
- Data_Out  out  DATA_BITS  last received data word.
- Data_Valid  out  1  one-cycle pulse: Data_Out/Rx_Error updated.
- Rx_Error  out  3  [2] frame, [1] parity, [0] break.
- Rx_Busy  out  1  frame reception in progress.
- RTS  out  1  ready-to-send; high = sender may transmit.

Behaviour:
- Reset (Rst low, async) values:
  - Data_Out=0, Data_Valid=0, Rx_Error=000, Rx_Busy=0, RTS=0.
  - Synchroniser flops preset to 1; state=IDLE; all counters 0.
  - First cycle after release: RTS = !Rx_Hold.
- Rx passes through a 2-flop synchroniser; all logic uses the synchronised value rxs (2 cycles latency).
- RTS is registered: RTS = !Rx_Hold, one-cycle latency. A frame already in progress always completes.
- States: IDLE, START, SHIFT, BREAK_WAIT.
- IDLE:
  - rxs=0 in cycle S -> START, clear bit counter, Rx_Busy=1 from S+1.
- START:
  - Sample rxs at S+H.
  - Sample 1 -> false start: back to IDLE, no Data_Valid, Rx_Busy=0.
  - Sample 0 -> SHIFT.
- SHIFT:
  - Frame bit k (k=1..FRAME_BITS-1) is sampled exactly at S+H+k*OVERSAMPLE.
  - Data bits shift in MSB-first.
  - Parity bit is compared with the XOR of the data bits.
  - Each stop bit is checked for 1.
- Completion, registered at cycle S+H+(FRAME_BITS-1)*OVERSAMPLE+1:
  - Data_Valid=1 for exactly that cycle.
  - Data_Out and Rx_Error are updated in the same cycle and held until the next Data_Valid.
  - Rx_Busy=0 in the same cycle.
- Error rules:
  - Break: every sampled bit (start, data, parity, stop) is 0 -> Rx_Error=001, Data_Out=0; next state BREAK_WAIT.
  - Otherwise Rx_Error[2] = any stop bit sampled 0, and Rx_Error[1] = parity mismatch (always 0 when PARITY_BIT=0). Both may be set together. Next state IDLE.
  - The frame is delivered even when errors are flagged.
- BREAK_WAIT: stays until rxs=1, then IDLE. No start detection while here.
- Back-to-back frames: a start edge immediately after the last stop-bit sample is accepted, with no dead cycles beyond the return to IDLE.
- Reset mid-frame: the frame is discarded, no Data_Valid, and all outputs take their reset values immediately.
- Rx_Hold never aborts or delays a frame; it only affects RTS.

Test Plan (defaults: FRAME_BITS=12, H=8):
- Valid frame: Rx drives 0,1010_0101,0,1,1, each bit 16 cycles, start edge synchronised at S -> one Data_Valid pulse at S+185, Data_Out=0xA5, Rx_Error=000, Rx_Busy high S+1..S+184.
- Parity error: data 0xAA with parity bit 1 -> Data_Out=0xAA, Rx_Error=010.
- Frame error: data 0xAA, parity 0, stop bits 0,0, then Rx=1 -> Rx_Error=100, state returns to IDLE.
- Break: Rx held 0 for 12 bits plus 40 extra cycles, then 1 -> exactly one Data_Valid with Rx_Error=001, Data_Out=0x00; no second frame; a following valid 0x3C frame is received correctly.
- Glitch and hold:
  - Rx low for 4 cycles -> no Data_Valid, Rx_Busy low again after the S+8 sample.
  - Rx_Hold raised mid-frame -> RTS low the next cycle, and the frame still completes with Data_Valid.
- Reset mid-frame: Rst pulsed low at bit 5 -> no Data_Valid; Data_Out=0, Rx_Error=000; next frame 0x5A received correctly.
